// File: rtl/bsg_axi_mem_responder.sv
`default_nettype none
// bsg_axi_mem_responder -- AXI4 slave over an internal word-addressed memory;
// serves one INCR read or write burst at a time (rev 1.0).
module bsg_axi_mem_responder #(
    parameter int axi_id_width_p   = 6,
    parameter int axi_addr_width_p = 64,
    parameter int axi_data_width_p = 512,
    parameter int mem_els_p        = 1024,
    localparam int strb_lp         = axi_data_width_p / 8,
    localparam int offset_lp       = $clog2(strb_lp),
    localparam int idx_lp          = $clog2(mem_els_p)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic [axi_id_width_p-1:0]   axi_awid_i,
    input  logic [axi_addr_width_p-1:0] axi_awaddr_i,
    input  logic [7:0]                  axi_awlen_i,
    input  logic [2:0]                  axi_awsize_i,
    input  logic [1:0]                  axi_awburst_i,
    input  logic [3:0]                  axi_awcache_i,
    input  logic [2:0]                  axi_awprot_i,
    input  logic                        axi_awlock_i,
    input  logic                        axi_awvalid_i,
    output logic                        axi_awready_o,

    input  logic [axi_data_width_p-1:0] axi_wdata_i,
    input  logic [strb_lp-1:0]          axi_wstrb_i,
    input  logic                        axi_wlast_i,
    input  logic                        axi_wvalid_i,
    output logic                        axi_wready_o,

    output logic [axi_id_width_p-1:0]   axi_bid_o,
    output logic [1:0]                  axi_bresp_o,
    output logic                        axi_bvalid_o,
    input  logic                        axi_bready_i,

    input  logic [axi_id_width_p-1:0]   axi_arid_i,
    input  logic [axi_addr_width_p-1:0] axi_araddr_i,
    input  logic [7:0]                  axi_arlen_i,
    input  logic [2:0]                  axi_arsize_i,
    input  logic [1:0]                  axi_arburst_i,
    input  logic [3:0]                  axi_arcache_i,
    input  logic [2:0]                  axi_arprot_i,
    input  logic                        axi_arlock_i,
    input  logic                        axi_arvalid_i,
    output logic                        axi_arready_o,

    output logic [axi_id_width_p-1:0]   axi_rid_o,
    output logic [axi_data_width_p-1:0] axi_rdata_o,
    output logic [1:0]                  axi_rresp_o,
    output logic                        axi_rlast_o,
    output logic                        axi_rvalid_o,
    input  logic                        axi_rready_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_e;

    state_e                      state, state_n;
    logic [axi_id_width_p-1:0]   txn_id;
    logic [idx_lp-1:0]           idx, aw_idx, ar_idx, rd_addr;
    logic [7:0]                  count, beat;
    logic                        err, prefer_write, rvalid;
    logic [axi_data_width_p-1:0] mem [mem_els_p];
    logic [axi_data_width_p-1:0] rdata;
    logic grant_w, grant_r, aw_fire, ar_fire, w_fire, b_fire, r_fire;
    logic beat_last, w_done, r_done, mem_we, rd_en;
    logic unused_inputs;

    assign unused_inputs = ^{axi_awaddr_i, axi_araddr_i, axi_awcache_i, axi_awprot_i,
                             axi_awlock_i, axi_arcache_i, axi_arprot_i, axi_arlock_i};

    assign aw_idx = axi_awaddr_i[offset_lp +: idx_lp];
    assign ar_idx = axi_araddr_i[offset_lp +: idx_lp];

    // On a tie the side not served last wins; prefer_write is write-first out of reset.
    assign grant_w = axi_awvalid_i && (!axi_arvalid_i || prefer_write);
    assign grant_r = axi_arvalid_i && !grant_w;

    assign axi_awready_o = (state == IDLE) && grant_w;
    assign axi_arready_o = (state == IDLE) && grant_r;
    assign axi_wready_o  = (state == WDATA);
    assign axi_bvalid_o  = (state == WRESP);
    assign axi_rvalid_o  = rvalid;

    assign aw_fire = axi_awvalid_i && axi_awready_o;
    assign ar_fire = axi_arvalid_i && axi_arready_o;
    assign w_fire  = axi_wvalid_i && axi_wready_o;
    assign b_fire  = axi_bvalid_o && axi_bready_i;
    assign r_fire  = rvalid && axi_rready_i;

    assign beat_last = (beat == count);
    assign w_done    = w_fire && (axi_wlast_i || beat_last);
    assign r_done    = r_fire && beat_last;

    assign axi_bid_o   = axi_bvalid_o ? txn_id : '0;
    assign axi_bresp_o = (axi_bvalid_o && err) ? 2'b10 : 2'b00;
    assign axi_rid_o   = rvalid ? txn_id : '0;
    assign axi_rresp_o = (rvalid && err) ? 2'b10 : 2'b00;
    assign axi_rlast_o = rvalid && beat_last;
    assign axi_rdata_o = rdata;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (aw_fire)      state_n = WDATA;
                else if (ar_fire) state_n = RDATA;
            end
            WDATA:   if (w_done) state_n = WRESP;
            WRESP:   if (b_fire) state_n = IDLE;
            RDATA:   if (r_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state        <= IDLE;
            prefer_write <= 1'b1;
            rvalid       <= 1'b0;
            err          <= 1'b0;
            txn_id       <= '0;
            idx          <= '0;
            count        <= '0;
            beat         <= '0;
        end else begin
            state <= state_n;
            if (aw_fire) begin
                txn_id       <= axi_awid_i;
                idx          <= aw_idx;
                count        <= axi_awlen_i;
                beat         <= '0;
                err          <= (axi_awburst_i != 2'b01) || (axi_awsize_i != 3'(offset_lp));
                prefer_write <= 1'b0;
            end
            if (ar_fire) begin
                txn_id       <= axi_arid_i;
                idx          <= ar_idx;
                count        <= axi_arlen_i;
                beat         <= '0;
                err          <= (axi_arburst_i != 2'b01) || (axi_arsize_i != 3'(offset_lp));
                prefer_write <= 1'b1;
                rvalid       <= 1'b1;
            end
            if (w_fire) begin
                idx  <= idx + 1'b1;
                beat <= beat + 1'b1;
                if (w_done && (axi_wlast_i != beat_last)) err <= 1'b1;
            end
            if (r_fire) begin
                if (beat_last) begin
                    rvalid <= 1'b0;
                end else begin
                    idx  <= idx + 1'b1;
                    beat <= beat + 1'b1;
                end
            end
        end
    end

    // Read data is fetched one beat ahead so a continuously-ready master sees no bubbles.
    assign rd_addr = ar_fire ? ar_idx : idx + 1'b1;
    assign rd_en   = ar_fire || (r_fire && !beat_last);
    assign mem_we  = w_fire && !err && reset_i;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < strb_lp; b++) begin
                if (axi_wstrb_i[b]) mem[idx][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
        if (rd_en) rdata <= mem[rd_addr];
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_axi_mem_responder.sv
`default_nettype none
// Bench for bsg_axi_mem_responder: directed and random bursts against a flat
// array memory model; a scoreboard monitor checks every B and R handshake.
module tb_bsg_axi_mem_responder;
    localparam int ID  = 6;
    localparam int AW  = 64;
    localparam int DW  = 128;
    localparam int MEM = 64;
    localparam int SW  = DW / 8;
    localparam int OFF = $clog2(SW);
    localparam int TMO = 300;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [ID-1:0] awid = '0, arid = '0;
    logic [AW-1:0] awaddr = '0, araddr = '0;
    logic [7:0] awlen = '0, arlen = '0;
    logic [2:0] awsize = '0, arsize = '0;
    logic [1:0] awburst = '0, arburst = '0;
    logic awvalid = 1'b0, arvalid = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic wlast = 1'b0, wvalid = 1'b0, bready = 1'b1, rready = 1'b1;
    logic [3:0] cache0 = '0;
    logic [2:0] prot0 = '0;
    logic lock0 = 1'b0;

    logic awready, arready, wready, bvalid, rvalid, rlast;
    logic [ID-1:0] bid, rid;
    logic [1:0] bresp, rresp;
    logic [DW-1:0] rdata;

    bsg_axi_mem_responder #(
        .axi_id_width_p(ID), .axi_addr_width_p(AW),
        .axi_data_width_p(DW), .mem_els_p(MEM)
    ) dut (
        .clk_i(clk), .reset_i(reset_n),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
        .axi_awsize_i(awsize), .axi_awburst_i(awburst), .axi_awcache_i(cache0),
        .axi_awprot_i(prot0), .axi_awlock_i(lock0), .axi_awvalid_i(awvalid),
        .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
        .axi_arsize_i(arsize), .axi_arburst_i(arburst), .axi_arcache_i(cache0),
        .axi_arprot_i(prot0), .axi_arlock_i(lock0), .axi_arvalid_i(arvalid),
        .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [ID-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [ID-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t exp_b[$];
    r_exp_t exp_r[$];
    int order_q[$];
    logic [DW-1:0] model [MEM];
    logic [DW-1:0] wbuf [256];
    logic [SW-1:0] sbuf [256];
    int checks = 0;
    int failures = 0;
    bit bp = 1'b0;

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic timeout(input string what);
        checks++;
        failures++;
        $display("FAIL timeout_%s actual=no_handshake required=handshake", what);
    endtask

    // Backpressure on B and R, random when bp is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            rready = bp ? 1'($urandom % 2) : 1'b1;
            bready = bp ? 1'($urandom % 2) : 1'b1;
        end
    end

    task automatic write_burst(input logic [ID-1:0] id, input logic [AW-1:0] addr, input int len,
                               input logic [1:0] burst, input logic [2:0] size, input bit wait_done);
        int cyc;
        bit err;
        b_exp_t e;
        err = (burst != 2'b01) || (size != 3'(OFF));
        if (!err) begin
            for (int i = 0; i <= len; i++) begin
                int k;
                k = int'(((addr >> OFF) + AW'(i)) % MEM);
                for (int b = 0; b < SW; b++)
                    if (sbuf[i][b]) model[k][8*b +: 8] = wbuf[i][8*b +: 8];
            end
        end
        e.id = id;
        e.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(e);
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size; awvalid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!awready && cyc < TMO) begin @(negedge clk); cyc++; end
        if (cyc >= TMO) timeout("aw");
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == len); wvalid = 1'b1;
            cyc = 0;
            @(negedge clk);
            while (!wready && cyc < TMO) begin @(negedge clk); cyc++; end
            if (cyc >= TMO) timeout("w");
            @(posedge clk); #1;
            wvalid = 1'b0; wlast = 1'b0;
        end
        if (wait_done) begin
            cyc = 0;
            while (exp_b.size() > 0 && cyc < TMO) begin @(posedge clk); cyc++; end
            if (cyc >= TMO) begin timeout("b"); exp_b.delete(); end
            @(posedge clk); #1;
        end
    endtask

    task automatic read_burst(input logic [ID-1:0] id, input logic [AW-1:0] addr, input int len,
                              input bit wait_done);
        int cyc;
        r_exp_t e;
        for (int i = 0; i <= len; i++) begin
            e.id = id;
            e.data = model[int'(((addr >> OFF) + AW'(i)) % MEM)];
            e.resp = 2'b00;
            e.last = (i == len);
            exp_r.push_back(e);
        end
        arid = id; araddr = addr; arlen = 8'(len); arburst = 2'b01; arsize = 3'(OFF); arvalid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!arready && cyc < TMO) begin @(negedge clk); cyc++; end
        if (cyc >= TMO) timeout("ar");
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (wait_done) begin
            cyc = 0;
            while (exp_r.size() > 0 && cyc < 4 * TMO) begin @(posedge clk); cyc++; end
            if (cyc >= 4 * TMO) begin timeout("r"); exp_r.delete(); end
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard monitor: samples at negedge, the handshakes of the coming posedge.
    logic [DW-1:0] sv_data;
    logic [ID-1:0] sv_id;
    logic [1:0] sv_resp;
    logic sv_last;
    bit stalled = 1'b0;
    r_exp_t re;
    b_exp_t be;

    always @(negedge clk) begin
        if (!reset_n) begin
            stalled = 1'b0;
        end else begin
            if (awvalid && awready) order_q.push_back(0);
            if (arvalid && arready) order_q.push_back(1);
            if (rvalid) begin
                if (stalled) begin
                    checks++;
                    if ({rdata, rid, rresp, rlast} !== {sv_data, sv_id, sv_resp, sv_last}) begin
                        failures++;
                        $display("FAIL r_stable actual=%h/%h/%h/%b required=%h/%h/%h/%b",
                                 rdata, rid, rresp, rlast, sv_data, sv_id, sv_resp, sv_last);
                    end
                end
                if (rready) begin
                    checks++;
                    stalled = 1'b0;
                    if (exp_r.size() == 0) begin
                        failures++;
                        $display("FAIL r_unexpected actual=beat data=%h required=no_beat", rdata);
                    end else begin
                        re = exp_r.pop_front();
                        if (rid !== re.id || rdata !== re.data || rresp !== re.resp || rlast !== re.last) begin
                            failures++;
                            $display("FAIL r_beat actual=id%h data%h resp%h last%b required=id%h data%h resp%h last%b",
                                     rid, rdata, rresp, rlast, re.id, re.data, re.resp, re.last);
                        end
                    end
                end else begin
                    stalled = 1'b1;
                    sv_data = rdata; sv_id = rid; sv_resp = rresp; sv_last = rlast;
                end
            end else begin
                stalled = 1'b0;
            end
            if (bvalid && bready) begin
                checks++;
                if (exp_b.size() == 0) begin
                    failures++;
                    $display("FAIL b_unexpected actual=bid%h required=no_response", bid);
                end else begin
                    be = exp_b.pop_front();
                    if (bid !== be.id || bresp !== be.resp) begin
                        failures++;
                        $display("FAIL b_resp actual=id%h resp%h required=id%h resp%h",
                                 bid, bresp, be.id, be.resp);
                    end
                end
            end
        end
    end

    initial begin
        int exp_order[4];
        logic [ID-1:0] tid;
        int cyc;
        exp_order = '{0, 1, 0, 1};

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_handshake actual=%b required=00000", {awready, arready, wready, bvalid, rvalid});
        end
        checks++;
        if ({bid, rid, bresp, rresp, rlast} !== '0) begin
            failures++;
            $display("FAIL reset_resp actual=%h required=0", {bid, rid, bresp, rresp, rlast});
        end
        @(posedge clk); #1;

        // Burst of 8 with data = beat index, read back with the same id.
        tid = 6'($urandom);
        for (int i = 0; i < 8; i++) begin wbuf[i] = DW'(i); sbuf[i] = '1; end
        write_burst(tid, 64'h0, 7, 2'b01, 3'(OFF), 1'b1);
        read_burst(tid, 64'h0, 7, 1'b1);

        // Fill the rest of memory so every later read has defined contents.
        for (int i = 0; i < MEM - 8; i++) begin wbuf[i] = rnd_data(); sbuf[i] = '1; end
        write_burst(6'd1, 64'(8 << OFF), MEM - 9, 2'b01, 3'(OFF), 1'b1);

        // Byte strobe merge at idx 3.
        wbuf[0] = '1; sbuf[0] = '1;
        write_burst(6'd2, 64'(3 << OFF), 0, 2'b01, 3'(OFF), 1'b1);
        wbuf[0] = '0; sbuf[0] = SW'(1);
        write_burst(6'd3, 64'(3 << OFF), 0, 2'b01, 3'(OFF), 1'b1);
        read_burst(6'd4, 64'(3 << OFF), 0, 1'b1);

        // Simultaneous requests: round-robin order W, R, W, R.
        order_q.delete();
        wbuf[0] = rnd_data(); sbuf[0] = '1;
        fork
            begin
                write_burst(6'd10, 64'(10 << OFF), 0, 2'b01, 3'(OFF), 1'b0);
                write_burst(6'd11, 64'(11 << OFF), 0, 2'b01, 3'(OFF), 1'b0);
            end
            begin
                read_burst(6'd20, 64'(20 << OFF), 0, 1'b0);
                read_burst(6'd21, 64'(21 << OFF), 0, 1'b0);
            end
        join
        cyc = 0;
        while ((exp_b.size() > 0 || exp_r.size() > 0) && cyc < TMO) begin @(posedge clk); cyc++; end
        if (cyc >= TMO) begin timeout("arb"); exp_b.delete(); exp_r.delete(); end
        @(posedge clk); #1;
        checks++;
        if (order_q.size() != 4 || order_q[0] != exp_order[0] || order_q[1] != exp_order[1] ||
            order_q[2] != exp_order[2] || order_q[3] != exp_order[3]) begin
            failures++;
            $display("FAIL arb_order actual=%p required=0,1,0,1 (0=W 1=R)", order_q);
        end

        // Wrap past the top of memory, plus an aliased high address bit.
        for (int i = 0; i < 4; i++) begin wbuf[i] = rnd_data(); sbuf[i] = '1; end
        write_burst(6'd5, 64'((MEM - 2) << OFF) | 64'h8000_0000_0000_0000, 3, 2'b01, 3'(OFF), 1'b1);
        read_burst(6'd6, 64'((MEM - 2) << OFF), 3, 1'b1);

        // Random traffic with backpressure, then a 16-beat read under stalls.
        bp = 1'b1;
        for (int t = 0; t < 24; t++) begin
            int len;
            logic [AW-1:0] a;
            len = $urandom_range(0, 7);
            a = {$urandom, $urandom};
            if ($urandom % 2) begin
                for (int i = 0; i <= len; i++) begin wbuf[i] = rnd_data(); sbuf[i] = SW'($urandom); end
                write_burst(6'($urandom), a, len, 2'b01, 3'(OFF), 1'b1);
            end else begin
                read_burst(6'($urandom), a, len, 1'b1);
            end
        end
        read_burst(6'd7, 64'(17 << OFF), 15, 1'b1);
        bp = 1'b0;
        @(posedge clk); #1;

        // FIXED burst: both beats accepted, SLVERR, memory untouched.
        for (int i = 0; i < 2; i++) begin wbuf[i] = rnd_data(); sbuf[i] = '1; end
        write_burst(6'd8, 64'(30 << OFF), 1, 2'b00, 3'(OFF), 1'b1);
        read_burst(6'd9, 64'(30 << OFF), 1, 1'b1);

        // Reset in the middle of a read burst.
        read_burst(6'd12, 64'(40 << OFF), 15, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_read_rvalid actual=%b required=0", rvalid);
        end
        exp_r.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        re.id = 6'd13; re.data = model[5]; re.resp = 2'b00; re.last = 1'b1;
        exp_r.push_back(re);
        arid = 6'd13; araddr = 64'(5 << OFF); arlen = 8'd0; arburst = 2'b01; arsize = 3'(OFF); arvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (arready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_arready actual=%b required=1", arready);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        cyc = 0;
        while (exp_r.size() > 0 && cyc < TMO) begin @(posedge clk); cyc++; end
        if (cyc >= TMO) begin timeout("post_reset_r"); exp_r.delete(); end

        repeat (5) @(posedge clk);
        checks++;
        if (exp_b.size() != 0 || exp_r.size() != 0) begin
            failures++;
            $display("FAIL leftover actual=b%0d_r%0d required=0_0", exp_b.size(), exp_r.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_axi_mem_responder.md
Name: bsg_axi_mem_responder

Overview:
- AXI4 slave (responder) backed by an internal word-addressed memory.
- Completes the initiator side of the off-chip interface used by the cache-to-AXI DMA path (multiple vcaches hashed onto one AXI4 port).
- Standalone simulation/FPGA-BRAM memory endpoint: accepts INCR read and write bursts and returns R/B responses.
- Exactly one transaction is in flight at a time.

Parameters:
- axi_id_width_p, 6, AXI ID width.
- axi_addr_width_p, 64, AXI address width.
- axi_data_width_p, 512, AXI data width in bits; must be a power of 2 and at least 32.
- mem_els_p, 1024, memory depth in axi_data_width_p words; must be a power of 2.
- Derived: strb_lp = axi_data_width_p/8; offset_lp = clog2(strb_lp); idx_lp = clog2(mem_els_p).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-low reset (0 = reset).
- axi_awid_i  in  axi_id_width_p  write ID.
- axi_awaddr_i  in  axi_addr_width_p  write start byte address.
- axi_awlen_i  in  8  beats-1.
- axi_awsize_i  in  3  beat size.
- axi_awburst_i  in  2  burst type.
- axi_awvalid_i  in  1 / axi_awready_o  out  1.
- axi_wdata_i  in  axi_data_width_p.
- axi_wstrb_i  in  strb_lp.
- axi_wlast_i  in  1.
- axi_wvalid_i  in  1 / axi_wready_o  out  1.
- axi_bid_o  out  axi_id_width_p.
- axi_bresp_o  out  2.
- axi_bvalid_o  out  1 / axi_bready_i  in  1.
- axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i: in, same widths as AW.
- axi_arvalid_i  in  1 / axi_arready_o  out  1.
- axi_rid_o  out  axi_id_width_p.
- axi_rdata_o  out  axi_data_width_p.
- axi_rresp_o  out  2.
- axi_rlast_o  out  1.
- axi_rvalid_o  out  1 / axi_rready_i  in  1.
- awcache/awprot/awlock/arcache/arprot/arlock: accepted as inputs, ignored.

Behaviour:
- Reset (reset_i=0 at a clock edge):
  - State goes to IDLE; all valid/ready outputs 0; bid/rid/bresp/rresp/rlast 0.
  - Priority flag set to write-first.
  - Memory contents are not reset.
  - Reset mid-burst abandons the burst; no B or R is issued for it.
- States: IDLE, WDATA, WRESP, RDATA.
- IDLE, arbitration:
  - awready_o/arready_o are combinational in IDLE only, asserted toward the arbitration winner.
  - If only one of awvalid/arvalid is high, that one wins.
  - If both are high, the side not served last wins (round-robin); the first tie after reset goes to write.
- AW handshake:
  - Latch id, idx = awaddr[offset_lp+:idx_lp], count = awlen.
  - Set err when awburst != INCR(2'b01) or awsize != offset_lp.
  - Go to WDATA.
- WDATA:
  - wready_o = 1.
  - Each handshake writes the bytes with wstrb=1 into mem[idx] (skipped when err); idx increments modulo mem_els_p.
  - A beat with wlast=1, or the beat at count exhausted, moves to WRESP.
  - A wlast/count mismatch sets err but still terminates on the earlier of the two.
- WRESP:
  - bvalid_o = 1, bid_o = latched id, bresp_o = err ? SLVERR(2'b10) : OKAY(2'b00).
  - Held stable until bready_i, then back to IDLE.
- AR handshake: latch id, idx, count = arlen, and err as for writes; go to RDATA.
- RDATA:
  - First rvalid_o is asserted the cycle after the AR handshake (registered synchronous-read memory).
  - rdata = mem[idx]; rresp = err ? SLVERR : OKAY; rlast_o = 1 on beat arlen.
  - rdata/rid/rresp/rlast are held stable while rvalid && !rready.
  - Each handshake advances idx (wrapping); a handshake on the rlast beat returns to IDLE.
  - With rready held high, one beat per cycle with no bubbles.
- Ordering: a read issued after a write's B handshake returns the written data.
- Address bits above offset_lp+idx_lp are ignored (aliasing). Burst wrap past mem_els_p-1 continues at 0.
- Throughput: a single-beat write takes at least 3 cycles (AW, W, B); a single-beat read takes at least 2 (AR, R).

Test Plan:
- Reset, then write len=7 from addr 0x0 with data i and full strobes, then read len=7 from 0x0 -> bresp=0; 8 R beats with data 0..7; rlast only on beat 7; rid=awid.
- Write one beat 0xFF..FF at idx 3, then write 0x00..00 with wstrb=0x1 at idx 3, then read idx 3 -> byte0=0x00 and all other bytes 0xFF.
- awvalid and arvalid asserted together for 4 consecutive transactions -> service order W, R, W, R.
- Write at idx mem_els_p-2 with len=3 -> data lands at idx mem_els_p-2, mem_els_p-1, 0, 1; readback matches.
- Random rready/bready backpressure at 50% during a len=15 read -> outputs held stable under stall; all 16 beats in order; exactly one rlast.
- awburst=FIXED, len=1 -> 2 W beats accepted, bresp=2'b10, memory unchanged. Separately, reset_i pulled low mid-read burst -> rvalid_o is 0 from the next cycle and arready_o is asserted in IDLE after release.
